// File: rtl/shift_chain_pkg.sv
// Shared types and defaults for the shift-chain controller.
// The shift_chain_ctrl bit order is selected by SHIFT_CHAIN_CTRL_LSB_FIRST_EN
// (defined: LSB first, undefined: MSB first).
package shift_chain_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_SHIFT_DIV = 4;

  // Bits needed to count 0..w inclusive, so a full transfer never wraps
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_chain_tick.sv
// Bit-rate divider: counts 0..SHIFT_DIV-1 while enabled and flags the last
// cycle of each bit period as the shift strobe.
module shift_chain_tick
  import shift_chain_pkg::*;
#(
  parameter int SHIFT_DIV = DEFAULT_SHIFT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Divider counter: cleared on a new transfer, wraps at the end of each bit
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked block and
    // is not in the sensitivity list.
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // NOTE: the strobe is a decode of registered state (counter and enable),
  // so it is glitch-free in practice and lands in the same cycle the counter
  // reaches its last value; registering it again would cost one cycle.
  assign tick = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/shift_chain_ctrl.sv
// Serial shift-chain controller: loads a word, clocks it out on so one bit
// per SHIFT_DIV cycles while capturing si, then reports the captured word.
// Bit order: define SHIFT_CHAIN_CTRL_LSB_FIRST_EN for LSB first; the default
// build shifts MSB first.
module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SHIFT_DIV = DEFAULT_SHIFT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             si,
  output logic             so,
  output logic             sclk_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
  localparam int OUT_BIT = 0;
`else
  localparam int OUT_BIT = WIDTH - 1;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             shifting;
  logic             tick;

  assign accept   = (state == IDLE) && start;
  assign shifting = (state == SHIFT);

  // Register contents after one shift, with si entering at the vacated end
`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
  assign sreg_shifted = {si, sreg[WIDTH-1:1]};
`else
  assign sreg_shifted = {sreg[WIDTH-2:0], si};
`endif

  shift_chain_tick #(
    .SHIFT_DIV (SHIFT_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (shifting),
    .tick  (tick)
  );

  assign sclk_en = tick;

  // Transfer FSM and data path; so, busy, done and rx_data are registered
  always_ff @(posedge clk) begin
    // NOTE: every state element here uses non-blocking assignment so all of
    // them see the pre-edge values of each other, whatever the statement order.
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      so      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sreg    <= tx_data;
            bit_cnt <= '0;
            so      <= tx_data[OUT_BIT];
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            sreg    <= sreg_shifted;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              // Last bit: the captured word is complete with this shift
              rx_data <= sreg_shifted;
              done    <= 1'b1;
              so      <= 1'b0;
              state   <= DONE;
            end else begin
              so <= sreg_shifted[OUT_BIT];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          so    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Testbench for shift_chain_ctrl: two instances (SHIFT_DIV=4 and 1) checked
// every cycle against a timeline model, plus directed literal scenarios.
// Honours SHIFT_CHAIN_CTRL_LSB_FIRST_EN for the expected bit order.
module tb_shift_chain_ctrl;

  localparam int W  = 8;
  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, si_drv, loop_mode;
  logic [W-1:0] tx_data;
  logic         so0, sclk0, busy0, done0, si0;
  logic         so1, sclk1, busy1, done1, si1;
  logic [W-1:0] rx0, rx1;

  assign si0 = loop_mode ? so0 : si_drv;
  assign si1 = loop_mode ? so1 : si_drv;

  shift_chain_ctrl #(.WIDTH(W), .SHIFT_DIV(D0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .si(si0),
    .so(so0), .sclk_en(sclk0), .busy(busy0), .done(done0), .rx_data(rx0)
  );

  shift_chain_ctrl #(.WIDTH(W), .SHIFT_DIV(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .si(si1),
    .so(so1), .sclk_en(sclk1), .busy(busy1), .done(done1), .rx_data(rx1)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Wire position of the k-th transferred bit (k = 1..W), both for so and rx
  function automatic int pos(input int k);
`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
    return k - 1;
`else
    return W - k;
`endif
  endfunction

  // ---------------- timeline model ----------------
  // A transfer is a timeline t = 1 .. W*d+1 counted from the accepting edge:
  // strobe when t is a multiple of d, bit k = ceil(t/d) on so, done at W*d+1.
  bit         act_m [2];
  int         t_m   [2];
  logic [W-1:0] tx_m [2];
  logic [W-1:0] acc_m[2];
  logic [W-1:0] rx_m [2];
  logic e_so[2], e_sclk[2], e_busy[2], e_done[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   d;
      int   k;
      logic si_now;
      d      = (i == 0) ? D0 : D1;
      si_now = (i == 0) ? si0 : si1;
      if (!rst_n) begin
        act_m[i] = 1'b0;
        t_m[i]   = 0;
        acc_m[i] = '0;
        rx_m[i]  = '0;
      end else if (act_m[i]) begin
        if (t_m[i] <= W * d && t_m[i] % d == 0) begin
          k = t_m[i] / d;
          acc_m[i][pos(k)] = si_now;
          if (k == W) rx_m[i] = acc_m[i];
        end
        if (t_m[i] == W * d + 1) act_m[i] = 1'b0;
        else                     t_m[i]++;
      end else if (start) begin
        act_m[i] = 1'b1;
        t_m[i]   = 1;
        tx_m[i]  = tx_data;
        acc_m[i] = '0;
      end
      e_busy[i] = act_m[i];
      e_done[i] = act_m[i] && (t_m[i] == W * d + 1);
      e_sclk[i] = act_m[i] && (t_m[i] <= W * d) && (t_m[i] % d == 0);
      if (act_m[i] && t_m[i] <= W * d)
        e_so[i] = tx_m[i][pos((t_m[i] + d - 1) / d)];
      else
        e_so[i] = 1'b0;
    end
  end

  // Compare process: every cycle, shortly after the active edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("so0",   {31'd0, so0},   {31'd0, e_so[0]});
      check("sclk0", {31'd0, sclk0}, {31'd0, e_sclk[0]});
      check("busy0", {31'd0, busy0}, {31'd0, e_busy[0]});
      check("done0", {31'd0, done0}, {31'd0, e_done[0]});
      check("rx0",   {24'd0, rx0},   {24'd0, rx_m[0]});
      check("so1",   {31'd0, so1},   {31'd0, e_so[1]});
      check("sclk1", {31'd0, sclk1}, {31'd0, e_sclk[1]});
      check("busy1", {31'd0, busy1}, {31'd0, e_busy[1]});
      check("done1", {31'd0, done1}, {31'd0, e_done[1]});
      check("rx1",   {24'd0, rx1},   {24'd0, rx_m[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int dones;
  int so_high;

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_data = '0; si_drv = 1'b0; loop_mode = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    // Reset state, literal
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_so",   {31'd0, so0},   32'd0);
    check("rst_sclk", {31'd0, sclk0}, 32'd0);
    check("rst_rx",   {24'd0, rx0},   32'd0);
    rst_n = 1'b1;
    step();

    // Loopback of 0xA5: strobes every 4 cycles up to 32, done at 33
    loop_mode = 1'b1; tx_data = 8'hA5; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      check("a_sclk", {31'd0, sclk0}, {31'd0, (c % 4 == 0) && (c <= 32)});
      check("a_done", {31'd0, done0}, {31'd0, c == 33});
      if (c == 33 || c == 40) check("a_rx", {24'd0, rx0}, 32'hA5);
      if (c == 34) check("a_busy", {31'd0, busy0}, 32'd0);
      step();
    end

    // si tied high, tx zero: so never rises, rx all ones
    loop_mode = 1'b0; si_drv = 1'b1; tx_data = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    so_high = 0;
    for (int c = 1; c <= 40; c++) begin
      if (so0) so_high++;
      if (c == 33) check("b_rx", {24'd0, rx0}, 32'hFF);
      step();
    end
    check("b_so_quiet", so_high, 0);
    repeat (12) step();

    // Starts at cycles 5 and 33 are ignored while busy
    loop_mode = 1'b1; tx_data = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done0) dones++;
      if (c == 34) check("c_busy", {31'd0, busy0}, 32'd0);
      if (c == 34) check("c_rx", {24'd0, rx0}, 32'h3C);
      start = (c == 5) || (c == 33);
      step();
    end
    start = 1'b0;
    check("c_dones", dones, 1);
    repeat (12) step();

    // Reset at cycle 10 aborts the transfer
    tx_data = 8'h5A; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done0) dones++;
      if (c >= 11 && c <= 14) begin
        check("d_busy", {31'd0, busy0}, 32'd0);
        check("d_so",   {31'd0, so0},   32'd0);
        check("d_sclk", {31'd0, sclk0}, 32'd0);
        check("d_rx",   {24'd0, rx0},   32'd0);
      end
      rst_n = (c != 10);
      step();
    end
    rst_n = 1'b1;
    check("d_dones", dones, 0);

    // start held: SHIFT_DIV=1 instance completes every W+2 cycles
    tx_data = 8'hC3; start = 1'b1;
    step();
    for (int c = 1; c <= 60; c++) begin
      check("e_done1", {31'd0, done1}, {31'd0, (c % (W + 2)) == (W + 1)});
      check("e_sclk1", {31'd0, sclk1}, {31'd0, busy1 && !done1});
      step();
    end
    start = 1'b0;
    repeat (40) step();

    // Single set bit shows the bit order on so
`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
    tx_data = 8'h01;
`else
    tx_data = 8'h80;
`endif
    loop_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      check("f_so", {31'd0, so0}, {31'd0, (c >= 1) && (c <= 4)});
      if (c == 33) check("f_rx", {24'd0, rx0}, {24'd0, tx_data});
      step();
    end

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      tx_data = W'($urandom);
      si_drv  = 1'($urandom);
      if ($urandom_range(0, 63) == 0) loop_mode = ~loop_mode;
      rst_n   = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
